// File: rtl/cpaep_pkg.sv
// ============================================================================
// Module      : cpaep_pkg
// Description : Shared widths and the output-pixel entry type for the
//               convolution output path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpaep_pkg;

    localparam int C_DATA_WIDTH  = 32;
    localparam int C_COORD_WIDTH = 32;

    typedef struct packed {
        logic [C_DATA_WIDTH-1:0]  data;
        logic [C_COORD_WIDTH-1:0] x;
        logic [C_COORD_WIDTH-1:0] y;
        logic [C_COORD_WIDTH-1:0] ch;
    } out_entry_t;

endpackage

`default_nettype wire

// File: rtl/output_drain_fifo_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Generic single-clock FIFO with registered pointers, occupancy
//               level and full/empty flags. Head is read straight from storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import cpaep_pkg::*;
#(
    parameter int WIDTH = C_DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                LW      = PW + 1;
    localparam logic [LW-1:0]     C_DEPTH = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == C_DEPTH);
    assign o_level = r_level;
    // Head reads as zero while empty so the outputs are clean after reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/output_drain_fifo.sv
// ============================================================================
// Module      : output_drain_fifo
// Description : Captures finished output pixels, buffers them and drains them
//               over valid/ready; tracks overflow and job completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_drain_fifo
    import cpaep_pkg::*;
#(
    parameter int DATA_WIDTH    = C_DATA_WIDTH,
    parameter int COORD_WIDTH   = C_COORD_WIDTH,
    parameter int DEPTH         = 4,
    parameter int TOTAL_OUTPUTS = 1024*1024*64
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COORD_WIDTH-1:0] in_x,
    input  logic [COORD_WIDTH-1:0] in_y,
    input  logic [COORD_WIDTH-1:0] in_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [COORD_WIDTH-1:0] out_ch,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic                   done
);

    localparam int            LW      = $clog2(DEPTH) + 1;
    localparam int            EW      = DATA_WIDTH + 3*COORD_WIDTH;
    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
    localparam logic [31:0]   C_TOTAL = 32'(TOTAL_OUTPUTS);

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_next;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;
    logic [31:0]   w_cnt_next;
    logic [31:0]   r_cnt;
    logic          r_overflow;
    logic          r_done;

    assign w_pop   = ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = in_valid & (~w_full | w_pop);
    assign w_wdata = {in_data, in_x, in_y, in_ch};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_level_next = w_level;
        if (w_push && !w_pop)
            w_level_next = w_level + LW'(1);
        else if (!w_push && w_pop)
            w_level_next = w_level - LW'(1);
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (start)
            w_cnt_next = '0;
        else if (w_pop && (r_cnt != C_TOTAL))
            w_cnt_next = r_cnt + 32'd1;
    end

    // done looks at next-state values so it rises right after the last pop.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (start)
                r_overflow <= 1'b0;
            else if (in_valid && !w_push)
                r_overflow <= 1'b1;
            if (start)
                r_done <= 1'b0;
            else if ((w_cnt_next == C_TOTAL) && (w_level_next == '0))
                r_done <= 1'b1;
        end
    end

    assign {out_data, out_x, out_y, out_ch} = w_rdata;
    assign out_valid   = ~w_empty;
    assign level       = w_level;
    assign almost_full = (w_level >= (C_DEPTH - LW'(1)));
    assign overflow    = r_overflow;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_output_drain_fifo.sv
// ============================================================================
// Module      : tb_output_drain_fifo
// Description : Directed scoreboard bench for output_drain_fifo (DEPTH=4,
//               TOTAL_OUTPUTS=6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_drain_fifo;
    import cpaep_pkg::*;

    localparam int C_DEPTH = 4;
    localparam int C_TOTAL = 6;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [31:0] in_ch = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_x;
    logic [31:0] out_y;
    logic [31:0] out_ch;
    logic        almost_full;
    logic        overflow;
    logic [2:0]  level;
    logic        done;

    int         vectors = 0;
    int         miscompares = 0;
    out_entry_t exp_q[$];

    output_drain_fifo #(
        .DATA_WIDTH    (32),
        .COORD_WIDTH   (32),
        .DEPTH         (C_DEPTH),
        .TOTAL_OUTPUTS (C_TOTAL)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_ch       (in_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .almost_full (almost_full),
        .overflow    (overflow),
        .level       (level),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one capture request; when it is expected to be accepted, queue it.
    task automatic drive(input logic [31:0] d, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] c, input bit accept);
        out_entry_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = c;
        if (accept) begin
            e.data = d; e.x = x; e.y = y; e.ch = c;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every handshake that the coming edge will complete is checked.
    always @(negedge clk) begin
        out_entry_t e;
        if (!rst_in && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got data %0d expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_x !== e.x || out_y !== e.y || out_ch !== e.ch) begin
                    miscompares++;
                    $display("FAIL pop_entry: got %0d (%0d,%0d,%0d) expected %0d (%0d,%0d,%0d)",
                             out_data, out_x, out_y, out_ch, e.data, e.x, e.y, e.ch);
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        bit          was_stalled;

        // Reset state
        tick(); tick();
        rst_in = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_almost_full", almost_full, 0);

        // Streaming: each entry leaves one cycle after its push
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'(10*(i+1)), 0, 0, 32'(i), 1'b1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_level", level, 1);
            chk("stream_data", out_data, 64'(10*(i+1)));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", level, 0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // Fill with stalled consumer, fifth push dropped
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(32'(99+k), 0, 1, 32'(k), 1'b1);
            tick();
            chk("fill_level", level, 64'(k));
            chk("fill_almost_full", almost_full, (k >= 3) ? 64'd1 : 64'd0);
            chk("fill_overflow", overflow, 0);
        end
        drive(104, 0, 1, 5, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_ovf", overflow, 0);
        chk("start_keeps_level", level, 4);

        // Full FIFO: push with simultaneous pop is accepted
        out_ready = 1'b1;
        drive(99, 9, 9, 9, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("fullpp_level", level, 4);
        chk("fullpp_overflow", overflow, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("fullpp_drained", level, 0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // Job of 6 outputs with toggling consumer; done right after 6th pop
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive(32'(200+c), 1, 2, 32'(c), 1'b1);
            else in_valid = 1'b0;
            out_ready   = c[0];
            was_stalled = out_valid && !out_ready;
            held        = out_data;
            tick();
            chk("job_done", done, (c == 11) ? 64'd1 : 64'd0);
            if (was_stalled) chk("job_stall_stable", out_data, held);
        end
        chk("job_level", level, 0);

        // done holds while new work buffers; start clears done and overflow
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(32'(300+k), 3, 3, 32'(k), k < 4);
            tick();
        end
        in_valid = 1'b0;
        chk("post_done_hold", done, 1);
        chk("post_overflow", overflow, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_done_clr", done, 0);
        chk("start_ovf_clr", overflow, 0);
        chk("start_level_kept", level, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("start_drain_level", level, 0);
        chk("start_cnt_restart", done, 0);

        // Reset mid-operation with three entries buffered
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(32'(400+k), 4, 4, 32'(k), 1'b1);
            tick();
        end
        drive(0, 0, 0, 0, 1'b0);
        in_valid = 1'b0;
        chk("prerst_level", level, 3);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_q.delete();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_level", level, 0);
        chk("midrst_overflow", overflow, 0);
        drive(500, 5, 5, 5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("postrst_valid", out_valid, 1);
        chk("postrst_data", out_data, 500);
        out_ready = 1'b1;
        tick();
        chk("final_level", level, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_drain_fifo.md
Name: output_drain_fifo

Overview:
- Downstream neighbour of the convolution controller/MAC datapath.
- Captures each finished output pixel (accumulator value plus x, y, ch tags) on the controller's one-cycle output-valid pulse.
- Buffers captured pixels in a small FIFO and drains them to the external consumer over a valid/ready handshake.
- Tracks overflow and counts emitted outputs so it can flag job completion.

Parameters:
- DATA_WIDTH, 32, width of accumulator output word.
- COORD_WIDTH, 32, width of each x/y/ch tag.
- DEPTH, 4, FIFO entries; must be a power of two, >= 2.
- TOTAL_OUTPUTS, 1024*1024*64, number of outputs in one job (FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS).

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous reset, active high.
- start  in  1  job start pulse; clears the output counter and the done flag.
- in_valid  in  1  output-valid pulse from the controller.
- in_data  in  DATA_WIDTH  accumulator result.
- in_x  in  COORD_WIDTH  output x tag.
- in_y  in  COORD_WIDTH  output y tag.
- in_ch  in  COORD_WIDTH  output channel tag.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_WIDTH  head data.
- out_x  out  COORD_WIDTH  head x tag.
- out_y  out  COORD_WIDTH  head y tag.
- out_ch  out  COORD_WIDTH  head channel tag.
- almost_full  out  1  high when count >= DEPTH-1; intended as a future stall request to the controller.
- overflow  out  1  sticky; set when a push is dropped.
- level  out  $clog2(DEPTH)+1  current occupancy.
- done  out  1  high when TOTAL_OUTPUTS entries have been popped and the FIFO is empty.

Behaviour:
- Reset (rst_in=1 at posedge) clears:
  - read pointer, write pointer and level (level=0);
  - out_valid=0, overflow=0, done=0, emitted counter=0;
  - out_data/x/y/ch are don't-care while out_valid=0 and are driven 0 after reset.
- Reset mid-operation discards all stored entries; no partial drain.
- Push:
  - Accepted when in_valid=1 and (level<DEPTH, or a pop happens in the same cycle).
  - The entry is written at the write pointer and the pointer wraps modulo DEPTH.
- Pop:
  - Occurs when out_valid=1 and out_ready=1; the read pointer advances with wrap.
  - out_valid=1 whenever level>0.
  - Head outputs are read from storage at the read pointer, so they are stable while out_valid=1 and out_ready=0.
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N, with out_valid high in cycle N+1.
  - There is no combinational in-to-out bypass, even when the FIFO is empty.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - This includes the full case: the push is accepted because a slot frees in the same cycle.
- Overflow: in_valid=1 with level==DEPTH and no pop means the push is dropped, overflow is set to 1, and stored entries are untouched. overflow clears only on rst_in or start.
- Pop on empty is impossible, since out_valid=0.
- out_ready while out_valid=0 is ignored.
- Emitted counter:
  - 32-bit; increments on each pop.
  - done is set when counter==TOTAL_OUTPUTS and level==0, and holds until start or rst_in.
  - Counter saturates at TOTAL_OUTPUTS; extra pops do not wrap it.
- start:
  - Clears the counter, done and overflow.
  - Does not flush FIFO contents.
  - If start coincides with a pop, the counter restarts at 0 and that pop is not counted.
- almost_full is combinational from the level register.
- level arithmetic is unsigned and one bit wider than the pointers, so full (DEPTH) is distinguishable from empty (0).

Decomposition:
- Shared package cpaep_pkg holds DATA_WIDTH and COORD_WIDTH defaults and a packed struct out_entry_t {data, x, y, ch}.
- One natural sub-module: sync_fifo, a generic width/depth FIFO with push/pop/level/full/empty.
- output_drain_fifo wraps sync_fifo and adds overflow, the emitted counter and done logic.

Test Plan:
- Reset, then 3 pushes (data 10/20/30, tags (0,0,0),(0,0,1),(0,0,2)) with out_ready=1 -> out_valid rises the cycle after the first push; 10, 20, 30 leave in order, each one cycle after its push; level never exceeds 1.
- out_ready=0, 5 pushes with DEPTH=4 -> level reaches 4; almost_full=1 from level 3; 5th push dropped; overflow=1; drain yields the first 4 entries only.
- Full FIFO, push data 99 in the same cycle as a pop -> level stays 4, overflow stays 0, and 99 emerges 4th.
- TOTAL_OUTPUTS=6: 6 pushes, consumer toggling out_ready 1/0 -> done=1 exactly the cycle after the 6th pop; head data stays stable while out_ready=0.
- rst_in asserted with level=3 -> next cycle out_valid=0, level=0, overflow=0; a push afterwards appears in one cycle.
- start pulse with done=1 and overflow=1 -> both clear and the counter returns to 0; buffered entries are still drained.
